// File: rtl/des_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | des_pkg : DES key-schedule tables, types and permutation helpers         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package des_pkg;

  typedef logic [55:0] cd_t;
  typedef logic [47:0] subkey_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Table entries use DES numbering: entry n selects DES bit n (MSB = bit 1).
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int SHIFT_SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic cd_t pc1_f(input logic [63:0] key);
    cd_t cd;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1_TAB[i])];
    return cd;
  endfunction

  function automatic subkey_t pc2_f(input cd_t cd);
    subkey_t sk;
    for (int i = 0; i < 48; i++) sk[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    return sk;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] v, input int s);
    return (v << s) | (v >> (28 - s));
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] v, input int s);
    return (v >> s) | (v << (28 - s));
  endfunction

  function automatic cd_t cd_rotl(input cd_t cd, input int s);
    return {rotl28(cd[55:28], s), rotl28(cd[27:0], s)};
  endfunction

  function automatic cd_t cd_rotr(input cd_t cd, input int s);
    return {rotr28(cd[55:28], s), rotr28(cd[27:0], s)};
  endfunction

  // Encrypt starts at K1 (first shift applied); decrypt starts at K16,
  // whose cumulative rotation of 28 equals the unrotated PC-1 value.
  function automatic cd_t cd_first(input cd_t cd, input logic dec);
    return dec ? cd : cd_rotl(cd, SHIFT_SCHED[0]);
  endfunction

  function automatic logic odd_parity_ok(input logic [63:0] key);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) ok = ok & (^key[b*8 +: 8]);
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_key_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | des_key_sched_if : key-load and subkey-stream handshakes                 |
// | Optional par_err signal with DES_KS_PARITY_CHK_EN.  Rev 1.0              |
// +--------------------------------------------------------------------------+
interface des_key_sched_if #(
  parameter int NUM_KEYS = 1,
  parameter int KIDX_W   = 2
);
  import des_pkg::*;

  logic                    key_valid;
  logic                    key_ready;
  logic [64*NUM_KEYS-1:0]  key_in;
  logic [NUM_KEYS-1:0]     key_dec;
  logic                    flush;
  logic                    subkey_valid;
  logic                    subkey_ready;
  subkey_t                 subkey;
  logic [3:0]              subkey_rnd;
  logic [KIDX_W-1:0]       subkey_kidx;
  logic                    subkey_last;
`ifdef DES_KS_PARITY_CHK_EN
  logic                    par_err;
`endif

  modport master (
    output key_valid, key_in, key_dec, flush, subkey_ready,
`ifdef DES_KS_PARITY_CHK_EN
    input  par_err,
`endif
    input  key_ready, subkey_valid, subkey, subkey_rnd, subkey_kidx, subkey_last
  );

  modport slave (
    input  key_valid, key_in, key_dec, flush, subkey_ready,
`ifdef DES_KS_PARITY_CHK_EN
    output par_err,
`endif
    output key_ready, subkey_valid, subkey, subkey_rnd, subkey_kidx, subkey_last
  );

endinterface
`default_nettype wire

// File: rtl/des_key_sched_pc1.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | des_pc1 : combinational PC-1, 64-bit key to 56-bit C/D                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module des_pc1
  import des_pkg::*;
(
  input  logic [63:0] key_i,
  output cd_t         cd_o
);
  assign cd_o = pc1_f(key_i);
endmodule
`default_nettype wire

// File: rtl/des_key_sched_pc2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | des_pc2 : combinational PC-2, 56-bit C/D to 48-bit subkey                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module des_pc2
  import des_pkg::*;
(
  input  cd_t     cd_i,
  output subkey_t subkey_o
);
  assign subkey_o = pc2_f(cd_i);
endmodule
`default_nettype wire

// File: rtl/des_key_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | des_key_sched : sequential DES/3DES key schedule, one subkey per cycle   |
// | Optional odd-parity key check with DES_KS_PARITY_CHK_EN.  Rev 1.0        |
// +--------------------------------------------------------------------------+
module des_key_sched
  import des_pkg::*;
#(
  parameter int NUM_KEYS = 1,
  parameter int KIDX_W   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  des_key_sched_if.slave  bus
);

  state_t                 state_q, state_d;
  cd_t                    cd_q, cd_d;
  logic [3:0]             rnd_q, rnd_d;
  logic [KIDX_W-1:0]      kidx_q, kidx_d;
  logic [64*NUM_KEYS-1:0] key_q, key_d;
  logic [NUM_KEYS-1:0]    dec_q, dec_d;

  cd_t  load_cd, nxt_cd;
  cd_t  pc1_cd [NUM_KEYS];
  logic load_hs, sk_hs, par_ok, cur_dec, nxt_dec, last_rnd, last_key;

  des_pc1 u_pc1_in (.key_i(bus.key_in[63:0]), .cd_o(load_cd));

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_pc1
    des_pc1 u_pc1 (.key_i(key_q[64*k +: 64]), .cd_o(pc1_cd[k]));
  end

  des_pc2 u_pc2 (.cd_i(cd_q), .subkey_o(bus.subkey));

`ifdef DES_KS_PARITY_CHK_EN
  logic                par_err_q, par_err_d;
  logic [NUM_KEYS-1:0] par_ok_k;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_par
    assign par_ok_k[k] = odd_parity_ok(bus.key_in[64*k +: 64]);
  end
  assign par_ok    = &par_ok_k;
  assign par_err_d = load_hs & ~par_ok & ~bus.flush;
`else
  assign par_ok = 1'b1;
`endif

  assign load_hs  = bus.key_valid & bus.key_ready;
  assign sk_hs    = bus.subkey_valid & bus.subkey_ready;
  assign last_rnd = (rnd_q == 4'd15);
  assign last_key = (int'(kidx_q) == NUM_KEYS - 1);

  // Direction of the active key and PC-1/direction of the one after it.
  always_comb begin
    cur_dec = 1'b0;
    nxt_dec = 1'b0;
    nxt_cd  = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (k == int'(kidx_q)) cur_dec = dec_q[k];
      if (k == int'(kidx_q) + 1) begin
        nxt_dec = dec_q[k];
        nxt_cd  = pc1_cd[k];
      end
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cd_q    <= '0;
      rnd_q   <= '0;
      kidx_q  <= '0;
      key_q   <= '0;
      dec_q   <= '0;
`ifdef DES_KS_PARITY_CHK_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      rnd_q   <= rnd_d;
      kidx_q  <= kidx_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
`ifdef DES_KS_PARITY_CHK_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    cd_d    = cd_q;
    rnd_d   = rnd_q;
    kidx_d  = kidx_q;
    key_d   = key_q;
    dec_d   = dec_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
      rnd_d   = '0;
      kidx_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_hs && par_ok) begin
            state_d = ST_EMIT;
            key_d   = bus.key_in;
            dec_d   = bus.key_dec;
            cd_d    = cd_first(load_cd, bus.key_dec[0]);
            rnd_d   = '0;
            kidx_d  = '0;
          end
        end
        ST_EMIT: begin
          if (sk_hs) begin
            if (!last_rnd) begin
              rnd_d = rnd_q + 4'd1;
              cd_d  = cur_dec ? cd_rotr(cd_q, SHIFT_SCHED[4'd15 - rnd_q])
                              : cd_rotl(cd_q, SHIFT_SCHED[rnd_q + 4'd1]);
            end else if (!last_key) begin
              kidx_d = kidx_q + KIDX_W'(1);
              rnd_d  = '0;
              cd_d   = cd_first(nxt_cd, nxt_dec);
            end else begin
              state_d = ST_IDLE;
              rnd_d   = '0;
              kidx_d  = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin : outputs
    bus.key_ready    = (state_q == ST_IDLE);
    bus.subkey_valid = (state_q == ST_EMIT);
    bus.subkey_rnd   = rnd_q;
    bus.subkey_kidx  = kidx_q;
    bus.subkey_last  = last_key & last_rnd & (state_q == ST_EMIT);
`ifdef DES_KS_PARITY_CHK_EN
    bus.par_err      = par_err_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_des_key_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_des_key_sched : directed bench, single-key and three-key instances    |
// | Parity scenario built with DES_KS_PARITY_CHK_EN.  Rev 1.0                |
// +--------------------------------------------------------------------------+
module tb_des_key_sched;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] K2  = 48'h79AED9DBC9E5;
  localparam logic [47:0] K15 = 48'hBF918D3D3F0A;
  localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  des_key_sched_if #(.NUM_KEYS(1), .KIDX_W(2)) b1 ();
  des_key_sched_if #(.NUM_KEYS(3), .KIDX_W(2)) b3 ();

  des_key_sched #(.NUM_KEYS(1), .KIDX_W(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  des_key_sched #(.NUM_KEYS(3), .KIDX_W(2)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load1(input logic [63:0] key, input logic dec);
    b1.key_in = key; b1.key_dec = dec; b1.key_valid = 1'b1;
    tick();
    b1.key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (b1.key_ready !== 1'b1) begin n_err++; $display("FAIL rst_key_ready got %b want 1", b1.key_ready); end
    n_cmp++; if (b1.subkey_valid !== 1'b0) begin n_err++; $display("FAIL rst_subkey_valid got %b want 0", b1.subkey_valid); end
    n_cmp++; if (b1.subkey_rnd !== 4'd0) begin n_err++; $display("FAIL rst_rnd got %0d want 0", b1.subkey_rnd); end
    n_cmp++; if (b1.subkey_kidx !== 2'd0) begin n_err++; $display("FAIL rst_kidx got %0d want 0", b1.subkey_kidx); end
    n_cmp++; if (b1.subkey_last !== 1'b0) begin n_err++; $display("FAIL rst_last got %b want 0", b1.subkey_last); end
    n_cmp++; if (b1.subkey !== 48'h0) begin n_err++; $display("FAIL rst_subkey got %h want 0", b1.subkey); end
    n_cmp++; if (b3.key_ready !== 1'b1) begin n_err++; $display("FAIL rst_key_ready3 got %b want 1", b3.key_ready); end
`ifdef DES_KS_PARITY_CHK_EN
    n_cmp++; if (b1.par_err !== 1'b0) begin n_err++; $display("FAIL rst_par_err got %b want 0", b1.par_err); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_encrypt();
    logic [47:0] exp;
    b1.subkey_ready = 1'b1;
    load1(KEY, 1'b0);
    for (int r = 0; r < 16; r++) begin
      n_cmp++; if (b1.subkey_valid !== 1'b1) begin n_err++; $display("FAIL enc_valid r=%0d got %b want 1", r, b1.subkey_valid); end
      n_cmp++; if (b1.subkey_rnd !== 4'(r)) begin n_err++; $display("FAIL enc_rnd got %0d want %0d", b1.subkey_rnd, r); end
      n_cmp++; if (b1.subkey_last !== (r == 15)) begin n_err++; $display("FAIL enc_last r=%0d got %b", r, b1.subkey_last); end
      exp = (r == 0) ? K1 : (r == 1) ? K2 : (r == 14) ? K15 : K16;
      if (r < 2 || r > 13) begin
        n_cmp++; if (b1.subkey !== exp) begin n_err++; $display("FAIL enc_subkey r=%0d got %h want %h", r, b1.subkey, exp); end
      end
      // Keys offered while busy must be ignored.
      b1.key_valid = (r >= 1 && r <= 13);
      b1.key_in    = '1;
      tick();
    end
    n_cmp++; if (b1.key_ready !== 1'b1) begin n_err++; $display("FAIL enc_done_ready got %b want 1", b1.key_ready); end
    n_cmp++; if (b1.subkey_valid !== 1'b0) begin n_err++; $display("FAIL enc_done_valid got %b want 0", b1.subkey_valid); end
  endtask

  task automatic test_decrypt();
    logic [47:0] exp;
    load1(KEY, 1'b1);
    for (int r = 0; r < 16; r++) begin
      exp = (r == 0) ? K16 : (r == 1) ? K15 : (r == 14) ? K2 : K1;
      if (r < 2 || r > 13) begin
        n_cmp++; if (b1.subkey !== exp) begin n_err++; $display("FAIL dec_subkey r=%0d got %h want %h", r, b1.subkey, exp); end
      end
      if (r == 15) begin
        n_cmp++; if (b1.subkey_last !== 1'b1) begin n_err++; $display("FAIL dec_last got %b want 1", b1.subkey_last); end
      end
      tick();
    end
    n_cmp++; if (b1.key_ready !== 1'b1) begin n_err++; $display("FAIL dec_done_ready got %b want 1", b1.key_ready); end
  endtask

  task automatic test_all_ones();
    load1(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    for (int r = 0; r < 16; r++) begin
      n_cmp++; if (b1.subkey !== 48'hFFFF_FFFF_FFFF) begin n_err++; $display("FAIL ones_subkey r=%0d got %h want ffffffffffff", r, b1.subkey); end
      tick();
    end
  endtask

  task automatic test_flush();
    load1(KEY, 1'b0);
    for (int r = 0; r < 7; r++) tick();
    n_cmp++; if (b1.subkey_rnd !== 4'd7) begin n_err++; $display("FAIL flush_pre_rnd got %0d want 7", b1.subkey_rnd); end
    b1.flush = 1'b1;
    tick();
    b1.flush = 1'b0;
    n_cmp++; if (b1.subkey_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", b1.subkey_valid); end
    n_cmp++; if (b1.key_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", b1.key_ready); end
    n_cmp++; if (b1.subkey_rnd !== 4'd0) begin n_err++; $display("FAIL flush_rnd got %0d want 0", b1.subkey_rnd); end
    b1.flush = 1'b1;
    load1(KEY, 1'b0);
    b1.flush = 1'b0;
    n_cmp++; if (b1.subkey_valid !== 1'b0) begin n_err++; $display("FAIL flush_prio_valid got %b want 0", b1.subkey_valid); end
    load1(KEY, 1'b0);
    n_cmp++; if (b1.subkey_valid !== 1'b1) begin n_err++; $display("FAIL restart_valid got %b want 1", b1.subkey_valid); end
    n_cmp++; if (b1.subkey_rnd !== 4'd0) begin n_err++; $display("FAIL restart_rnd got %0d want 0", b1.subkey_rnd); end
    n_cmp++; if (b1.subkey !== K1) begin n_err++; $display("FAIL restart_subkey got %h want %h", b1.subkey, K1); end
    b1.flush = 1'b1;
    tick();
    b1.flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    load1(KEY, 1'b0);
    for (int r = 0; r < 5; r++) tick();
    n_cmp++; if (b1.subkey_rnd !== 4'd5) begin n_err++; $display("FAIL rmid_pre_rnd got %0d want 5", b1.subkey_rnd); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if (b1.key_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready got %b want 1", b1.key_ready); end
    n_cmp++; if (b1.subkey_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b want 0", b1.subkey_valid); end
    n_cmp++; if (b1.subkey_rnd !== 4'd0) begin n_err++; $display("FAIL rmid_rnd got %0d want 0", b1.subkey_rnd); end
    n_cmp++; if (b1.subkey !== 48'h0) begin n_err++; $display("FAIL rmid_subkey got %h want 0", b1.subkey); end
  endtask

  task automatic test_3des();
    int n = 0, cyc = 0, kk, r;
    logic hold = 1'b0, dec, rdy;
    logic [47:0] s_sk, exp;
    logic [3:0]  s_rnd;
    logic [1:0]  s_kidx;
    logic        s_last;
    b3.key_in = {KEY, KEY, KEY}; b3.key_dec = 3'b010; b3.key_valid = 1'b1;
    tick();
    b3.key_valid = 1'b0;
    while (n < 48 && cyc < 2000) begin
      if (hold) begin
        n_cmp++;
        if ({b3.subkey, b3.subkey_rnd, b3.subkey_kidx, b3.subkey_last} !== {s_sk, s_rnd, s_kidx, s_last}) begin
          n_err++; $display("FAIL stall_hold n=%0d got %h/%0d/%0d want %h/%0d/%0d", n, b3.subkey, b3.subkey_rnd, b3.subkey_kidx, s_sk, s_rnd, s_kidx);
        end
      end
      n_cmp++;
      if (b3.subkey_valid !== 1'b1) begin
        n_err++; $display("FAIL 3des_valid n=%0d got %b want 1", n, b3.subkey_valid);
      end else begin
        rdy = 1'($urandom_range(0, 1));
        b3.subkey_ready = rdy;
        kk = n / 16; r = n % 16; dec = (kk == 1);
        n_cmp++; if (b3.subkey_kidx !== 2'(kk) || b3.subkey_rnd !== 4'(r)) begin n_err++; $display("FAIL 3des_idx n=%0d got %0d/%0d want %0d/%0d", n, b3.subkey_kidx, b3.subkey_rnd, kk, r); end
        n_cmp++; if (b3.subkey_last !== (n == 47)) begin n_err++; $display("FAIL 3des_last n=%0d got %b", n, b3.subkey_last); end
        if (r < 2 || r > 13) begin
          exp = (r == 0) ? (dec ? K16 : K1) : (r == 1) ? (dec ? K15 : K2) : (r == 14) ? (dec ? K2 : K15) : (dec ? K1 : K16);
          n_cmp++; if (b3.subkey !== exp) begin n_err++; $display("FAIL 3des_subkey n=%0d got %h want %h", n, b3.subkey, exp); end
        end
        hold = ~rdy;
        s_sk = b3.subkey; s_rnd = b3.subkey_rnd; s_kidx = b3.subkey_kidx; s_last = b3.subkey_last;
        if (rdy) n++;
      end
      tick();
      cyc++;
    end
    n_cmp++; if (n != 48) begin n_err++; $display("FAIL 3des_count got %0d want 48", n); end
    n_cmp++; if (b3.key_ready !== 1'b1 || b3.subkey_valid !== 1'b0) begin n_err++; $display("FAIL 3des_done got ready=%b valid=%b want 1/0", b3.key_ready, b3.subkey_valid); end
  endtask

`ifdef DES_KS_PARITY_CHK_EN
  task automatic test_parity();
    load1(64'h133457799BBCDFF0, 1'b0);
    n_cmp++; if (b1.par_err !== 1'b1) begin n_err++; $display("FAIL par_err_pulse got %b want 1", b1.par_err); end
    n_cmp++; if (b1.subkey_valid !== 1'b0 || b1.key_ready !== 1'b1) begin n_err++; $display("FAIL par_no_stream got valid=%b ready=%b want 0/1", b1.subkey_valid, b1.key_ready); end
    tick();
    n_cmp++; if (b1.par_err !== 1'b0) begin n_err++; $display("FAIL par_err_clear got %b want 0", b1.par_err); end
    load1(KEY, 1'b0);
    n_cmp++; if (b1.par_err !== 1'b0 || b1.subkey !== K1) begin n_err++; $display("FAIL par_good got err=%b sk=%h want 0/%h", b1.par_err, b1.subkey, K1); end
    b1.flush = 1'b1;
    tick();
    b1.flush = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    b1.key_valid = 1'b0; b1.key_in = '0; b1.key_dec = '0; b1.flush = 1'b0; b1.subkey_ready = 1'b1;
    b3.key_valid = 1'b0; b3.key_in = '0; b3.key_dec = '0; b3.flush = 1'b0; b3.subkey_ready = 1'b1;
    #2;
    test_reset();
    test_encrypt();
    test_decrypt();
`ifndef DES_KS_PARITY_CHK_EN
    test_all_ones();
`endif
    test_flush();
    test_reset_mid();
    test_3des();
`ifdef DES_KS_PARITY_CHK_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
